rob_commit: RTL and testbench

- Small in-order commit queue that is the write-side initiator for the 32x32 register file.
- The issue stage allocates entries in program order. Execution units write results back out of order by tag.
- The block retires the head entry to the register file through set_reg/set_val, one per cycle.
- It also provides tag-based operand lookup so issue can forward uncommitted results.

---
 rtl/rob_commit_pkg.sv | 13 +
 rtl/rob_commit.sv | 85 ++++++++
 tb/tb_rob_commit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: shared widths, default sizing and entry layout for the commit queue.
package rob_commit_pkg;
  localparam int DEF_ROB_DEPTH = 8;
  localparam int DEF_ROB_IDX_W = 3;
  localparam int REG_IDX_W = 5;
  localparam int XLEN = 32;
  typedef struct packed {
    logic busy;
    logic ready;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0] val;
  } rob_entry_t;
endpackage

// File: rtl/rob_commit.sv
// rob_commit: in-order commit queue retiring out-of-order writebacks to the register file.
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int ROB_DEPTH = DEF_ROB_DEPTH,
  parameter int ROB_IDX_W = DEF_ROB_IDX_W
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush,
  input  logic                 alloc_valid,
  input  logic [REG_IDX_W-1:0] alloc_rd,
  output logic                 alloc_ready,
  output logic [ROB_IDX_W-1:0] alloc_tag,
  input  logic                 wb_valid,
  input  logic [ROB_IDX_W-1:0] wb_tag,
  input  logic [XLEN-1:0]      wb_val,
  input  logic [ROB_IDX_W-1:0] q_tag,
  output logic                 q_ready,
  output logic [XLEN-1:0]      q_val,
  output logic [REG_IDX_W-1:0] set_reg,
  output logic [XLEN-1:0]      set_val,
  output logic                 commit_valid,
  output logic [ROB_IDX_W-1:0] commit_tag,
  output logic [ROB_IDX_W:0]   count
);
  rob_entry_t ent [ROB_DEPTH];
  logic [ROB_IDX_W-1:0] head, tail;
  logic do_alloc, do_commit;
  always_comb begin
    alloc_ready = count != (ROB_IDX_W+1)'(ROB_DEPTH);
    alloc_tag = tail;
    q_ready = ent[q_tag].busy & ent[q_tag].ready;
    q_val = ent[q_tag].val;
    do_alloc = alloc_valid & alloc_ready;
    do_commit = ent[head].busy & ent[head].ready;
  end
  // Commit decision uses pre-edge state, so a writeback never retires in its own cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < ROB_DEPTH; i++) ent[i] <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      set_reg <= '0;
      set_val <= '0;
      commit_valid <= 1'b0;
      commit_tag <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
          ent[i].busy <= 1'b0;
          ent[i].ready <= 1'b0;
        end
        head <= '0;
        tail <= '0;
        count <= '0;
        set_reg <= '0;
        commit_valid <= 1'b0;
      end else begin
        if (wb_valid && ent[wb_tag].busy) begin
          ent[wb_tag].val <= wb_val;
          ent[wb_tag].ready <= 1'b1;
        end
        if (do_commit) begin
          ent[head].busy <= 1'b0;
          ent[head].ready <= 1'b0;
          head <= head + ROB_IDX_W'(1);
        end
        if (do_alloc) begin
          ent[tail].busy <= 1'b1;
          ent[tail].ready <= 1'b0;
          ent[tail].rd <= alloc_rd;
          tail <= tail + ROB_IDX_W'(1);
        end
        set_reg <= do_commit ? ent[head].rd : '0;
        set_val <= do_commit ? ent[head].val : set_val;
        commit_valid <= do_commit;
        commit_tag <= do_commit ? head : commit_tag;
        count <= count + (ROB_IDX_W+1)'(do_alloc) - (ROB_IDX_W+1)'(do_commit);
      end
    end
  end
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed scenario tests for the commit queue.
module tb_rob_commit;
  logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, flush = 1'b0;
  logic alloc_valid = 1'b0, wb_valid = 1'b0;
  logic [4:0] alloc_rd = '0;
  logic [2:0] wb_tag = '0, q_tag = '0;
  logic [31:0] wb_val = '0;
  logic alloc_ready, q_ready, commit_valid;
  logic [2:0] alloc_tag, commit_tag;
  logic [31:0] q_val, set_val;
  logic [4:0] set_reg;
  logic [3:0] count;
  int checks = 0, errors = 0;

  rob_commit dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
    .q_tag(q_tag), .q_ready(q_ready), .q_val(q_val),
    .set_reg(set_reg), .set_val(set_val), .commit_valid(commit_valid), .commit_tag(commit_tag),
    .count(count)
  );

  always #5 clk_in = ~clk_in;

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic apply_reset();
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0;
    cyc();
    cyc();
    rst_in = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (set_reg !== 5'd0 || count !== 4'd0 || alloc_ready !== 1'b1 || alloc_tag !== 3'd0 || commit_valid !== 1'b0)
      begin errors++; $display("FAIL reset: set_reg=%0d count=%0d alloc_ready=%0b alloc_tag=%0d cv=%0b, want 0 0 1 0 0", set_reg, count, alloc_ready, alloc_tag, commit_valid); end
  endtask

  task automatic test_ooo();
    apply_reset();
    alloc_valid = 1'b1; alloc_rd = 5'd5; #1;
    checks++;
    if (alloc_tag !== 3'd0) begin errors++; $display("FAIL ooo_tag0: got %0d want 0", alloc_tag); end
    cyc();
    alloc_rd = 5'd7; #1;
    checks++;
    if (alloc_tag !== 3'd1) begin errors++; $display("FAIL ooo_tag1: got %0d want 1", alloc_tag); end
    cyc();
    alloc_valid = 1'b0; wb_valid = 1'b1; wb_tag = 3'd1; wb_val = 32'h22;
    cyc();
    checks++;
    if (commit_valid !== 1'b0 || count !== 4'd2) begin errors++; $display("FAIL ooo_nocommit: cv=%0b count=%0d want 0 2", commit_valid, count); end
    wb_tag = 3'd0; wb_val = 32'h11;
    cyc();
    wb_valid = 1'b0;
    checks++;
    if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_nobypass: cv=%0b want 0", commit_valid); end
    cyc();
    checks++;
    if (commit_valid !== 1'b1 || set_reg !== 5'd5 || set_val !== 32'h11 || commit_tag !== 3'd0)
      begin errors++; $display("FAIL ooo_commit0: cv=%0b reg=%0d val=%h tag=%0d want 1 5 11 0", commit_valid, set_reg, set_val, commit_tag); end
    cyc();
    checks++;
    if (commit_valid !== 1'b1 || set_reg !== 5'd7 || set_val !== 32'h22 || commit_tag !== 3'd1)
      begin errors++; $display("FAIL ooo_commit1: cv=%0b reg=%0d val=%h tag=%0d want 1 7 22 1", commit_valid, set_reg, set_val, commit_tag); end
    cyc();
    checks++;
    if (commit_valid !== 1'b0 || set_reg !== 5'd0 || set_val !== 32'h22 || count !== 4'd0)
      begin errors++; $display("FAIL ooo_idle: cv=%0b reg=%0d val=%h count=%0d want 0 0 22 0", commit_valid, set_reg, set_val, count); end
  endtask

  task automatic test_full_wrap();
    apply_reset();
    alloc_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      alloc_rd = 5'(i + 1);
      cyc();
    end
    checks++;
    if (count !== 4'd8 || alloc_ready !== 1'b0) begin errors++; $display("FAIL full: count=%0d ready=%0b want 8 0", count, alloc_ready); end
    alloc_rd = 5'd31;
    cyc();
    alloc_valid = 1'b0;
    checks++;
    if (count !== 4'd8 || alloc_tag !== 3'd0) begin errors++; $display("FAIL full_ignore: count=%0d tag=%0d want 8 0", count, alloc_tag); end
    wb_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wb_tag = 3'(i); wb_val = 32'h100 + 32'(i);
      cyc();
      if (i > 0) begin
        checks++;
        if (commit_valid !== 1'b1 || set_reg !== 5'(i) || set_val !== 32'h100 + 32'(i - 1) || commit_tag !== 3'(i - 1))
          begin errors++; $display("FAIL full_commit%0d: cv=%0b reg=%0d val=%h tag=%0d", i - 1, commit_valid, set_reg, set_val, commit_tag); end
      end
    end
    wb_valid = 1'b0;
    cyc();
    checks++;
    if (commit_valid !== 1'b1 || set_reg !== 5'd8 || set_val !== 32'h107 || commit_tag !== 3'd7 || count !== 4'd0)
      begin errors++; $display("FAIL full_commit7: cv=%0b reg=%0d val=%h tag=%0d count=%0d", commit_valid, set_reg, set_val, commit_tag, count); end
    alloc_valid = 1'b1; alloc_rd = 5'd3; #1;
    checks++;
    if (alloc_tag !== 3'd0 || alloc_ready !== 1'b1) begin errors++; $display("FAIL wrap_tag: tag=%0d ready=%0b want 0 1", alloc_tag, alloc_ready); end
    cyc();
    alloc_valid = 1'b0;
    checks++;
    if (count !== 4'd1 || alloc_tag !== 3'd1 || commit_valid !== 1'b0) begin errors++; $display("FAIL wrap_alloc: count=%0d tag=%0d cv=%0b want 1 1 0", count, alloc_tag, commit_valid); end
  endtask

  task automatic test_flush();
    apply_reset();
    alloc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alloc_rd = 5'(i + 1);
      cyc();
    end
    alloc_valid = 1'b0; wb_valid = 1'b1; wb_tag = 3'd1; wb_val = 32'hB1;
    cyc();
    wb_tag = 3'd0; wb_val = 32'hB0;
    cyc();
    q_tag = 3'd0; #1;
    checks++;
    if (count !== 4'd4 || q_ready !== 1'b1 || q_val !== 32'hB0) begin errors++; $display("FAIL flush_pre: count=%0d q_ready=%0b q_val=%h want 4 1 b0", count, q_ready, q_val); end
    flush = 1'b1; wb_tag = 3'd2; wb_val = 32'hB2; alloc_valid = 1'b1; alloc_rd = 5'd9;
    cyc();
    flush = 1'b0; wb_valid = 1'b0; alloc_valid = 1'b0;
    checks++;
    if (commit_valid !== 1'b0 || set_reg !== 5'd0 || count !== 4'd0 || alloc_tag !== 3'd0)
      begin errors++; $display("FAIL flush: cv=%0b reg=%0d count=%0d tag=%0d want 0 0 0 0", commit_valid, set_reg, count, alloc_tag); end
    q_tag = 3'd2; #1;
    checks++;
    if (q_ready !== 1'b0) begin errors++; $display("FAIL flush_wb_dropped: q_ready=%0b want 0", q_ready); end
    cyc();
    checks++;
    if (commit_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL flush_after: cv=%0b count=%0d want 0 0", commit_valid, count); end
  endtask

  task automatic test_stall();
    apply_reset();
    alloc_valid = 1'b1; alloc_rd = 5'd6;
    cyc();
    alloc_valid = 1'b0; wb_valid = 1'b1; wb_tag = 3'd0; wb_val = 32'h55;
    cyc();
    wb_valid = 1'b0; rdy_in = 1'b0; alloc_valid = 1'b1; alloc_rd = 5'd2;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (commit_valid !== 1'b0 || count !== 4'd1 || alloc_tag !== 3'd1)
        begin errors++; $display("FAIL stall%0d: cv=%0b count=%0d tag=%0d want 0 1 1", i, commit_valid, count, alloc_tag); end
    end
    alloc_valid = 1'b0; rdy_in = 1'b1;
    cyc();
    checks++;
    if (commit_valid !== 1'b1 || set_reg !== 5'd6 || set_val !== 32'h55 || commit_tag !== 3'd0 || count !== 4'd0)
      begin errors++; $display("FAIL stall_release: cv=%0b reg=%0d val=%h tag=%0d count=%0d", commit_valid, set_reg, set_val, commit_tag, count); end
  endtask

  task automatic test_lookup_x0();
    apply_reset();
    wb_valid = 1'b1; wb_tag = 3'd5; wb_val = 32'h77;
    cyc();
    wb_valid = 1'b0; alloc_valid = 1'b1; alloc_rd = 5'd0;
    cyc();
    alloc_valid = 1'b0; q_tag = 3'd5; #1;
    checks++;
    if (q_ready !== 1'b0) begin errors++; $display("FAIL wb_nonbusy: q_ready=%0b want 0", q_ready); end
    q_tag = 3'd0; wb_valid = 1'b1; wb_tag = 3'd0; wb_val = 32'hDEAD; #1;
    checks++;
    if (q_ready !== 1'b0) begin errors++; $display("FAIL lookup_nobypass: q_ready=%0b want 0", q_ready); end
    cyc();
    wb_valid = 1'b0; #1;
    checks++;
    if (q_ready !== 1'b1 || q_val !== 32'hDEAD || commit_valid !== 1'b0)
      begin errors++; $display("FAIL lookup: q_ready=%0b q_val=%h cv=%0b want 1 dead 0", q_ready, q_val, commit_valid); end
    cyc();
    checks++;
    if (commit_valid !== 1'b1 || set_reg !== 5'd0 || set_val !== 32'hDEAD || commit_tag !== 3'd0 || q_ready !== 1'b0)
      begin errors++; $display("FAIL x0_commit: cv=%0b reg=%0d val=%h tag=%0d q_ready=%0b", commit_valid, set_reg, set_val, commit_tag, q_ready); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    alloc_valid = 1'b1; alloc_rd = 5'd4;
    cyc();
    alloc_valid = 1'b0; wb_valid = 1'b1; wb_tag = 3'd0; wb_val = 32'h99;
    cyc();
    wb_valid = 1'b0; #2;
    rst_in = 1'b1; #1;
    checks++;
    if (count !== 4'd0 || commit_valid !== 1'b0 || set_reg !== 5'd0 || alloc_tag !== 3'd0)
      begin errors++; $display("FAIL async_reset: count=%0d cv=%0b reg=%0d tag=%0d want 0 0 0 0", count, commit_valid, set_reg, alloc_tag); end
    cyc();
    rst_in = 1'b0;
    cyc();
    checks++;
    if (commit_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL async_no_commit: cv=%0b count=%0d want 0 0", commit_valid, count); end
  endtask

  initial begin
    test_reset();
    test_ooo();
    test_full_wrap();
    test_flush();
    test_stall();
    test_lookup_x0();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
